// File: rtl/noc_pkg.sv
// Shared types and helpers for the mesh router scheduler: port indices,
// one-hot turn constants, dimension-order route decode and round-robin rotation.
package noc_pkg;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  localparam int unsigned NUM_PORTS = 5;

  // Turn/request vectors put N at the MSB, so port index p lives at bit 4-p.
  localparam logic [4:0] TURN_N = 5'b10000;
  localparam logic [4:0] TURN_S = 5'b01000;
  localparam logic [4:0] TURN_E = 5'b00100;
  localparam logic [4:0] TURN_W = 5'b00010;
  localparam logic [4:0] TURN_L = 5'b00001;

  function automatic logic [2:0] port_bit(input logic [2:0] p);
    return 3'(3'd4 - p);
  endfunction

  // Y-first dimension-order routing on unsigned 4-bit coordinates.
  function automatic port_e route_xy(input logic [7:0] data,
                                     input logic [3:0] xcoord,
                                     input logic [3:0] ycoord);
    logic [3:0] dx;
    logic [3:0] dy;
    dx = data[7:4];
    dy = data[3:0];
    if (dy > ycoord)      return PORT_S;
    else if (dy < ycoord) return PORT_N;
    else if (dx > xcoord) return PORT_E;
    else if (dx < xcoord) return PORT_W;
    else                  return PORT_L;
  endfunction

  // First requester strictly after the current holder, walking N->S->E->W->L->N
  // (MSB towards LSB, wrapping). The holder itself is never chosen; with no
  // other requester the turn is returned unchanged.
  function automatic logic [4:0] next_rr(input logic [4:0] turn,
                                         input logic [4:0] req);
    logic [2:0] h;
    logic [2:0] b;
    logic [4:0] res;
    h   = 3'd0;
    res = turn;
    for (int i = 0; i < 5; i++) begin
      if (turn[i]) h = 3'(i);
    end
    for (int k = 4; k >= 1; k--) begin
      b = 3'((int'(h) + 5 - k) % 5);
      if (req[b]) res = 5'b00001 << b;
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_out_arbiter.sv
// One output port: round-robin turn register, downstream credit counter and
// sticky credit error flag.
module noc_out_arbiter
  import noc_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req,
  input  logic       port_enable,
  input  logic       credit_ret,
  output logic [4:0] turn,
  output logic       port_full,
  output logic       credit_err
);

  localparam logic [3:0] DEPTH = 4'(BUF_DEPTH);

  logic [4:0] turn_q;
  logic [4:0] turn_d;
  logic [3:0] credits_q;
  logic [3:0] credits_d;
  logic       err_q;
  logic       err_d;
  logic       dec;
  logic       inc;

  // The holder keeps the port while it still requests and nothing was written;
  // a write or an idle holder passes the turn on.
  always_comb begin
    turn_d = turn_q;
    if (port_enable || ((req & turn_q) == 5'b00000)) begin
      turn_d = next_rr(turn_q, req);
    end
  end

  assign dec = port_enable & ~credit_ret;
  assign inc = credit_ret & ~port_enable;

  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (dec) begin
      if (credits_q == 4'd0) err_d = 1'b1;
      else                   credits_d = credits_q - 4'd1;
    end else if (inc) begin
      if (credits_q == DEPTH) err_d = 1'b1;
      else                    credits_d = credits_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      turn_q    <= TURN_N;
      credits_q <= DEPTH;
      err_q     <= 1'b0;
    end else begin
      turn_q    <= turn_d;
      credits_q <= credits_d;
      err_q     <= err_d;
    end
  end

  assign turn       = turn_q;
  assign port_full  = (credits_q == 4'd0);
  assign credit_err = err_q;

endmodule

// File: rtl/noc_turn_scheduler.sv
// Per-router output scheduler: decodes each input head flit to its output and
// runs one arbiter per output port.
module noc_turn_scheduler
  import noc_pkg::*;
#(
  parameter int unsigned XCOORD    = 0,
  parameter int unsigned YCOORD    = 0,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] N_data_i,
  input  logic [7:0] S_data_i,
  input  logic [7:0] E_data_i,
  input  logic [7:0] W_data_i,
  input  logic [7:0] L_data_i,
  input  logic       N_valid_i,
  input  logic       S_valid_i,
  input  logic       E_valid_i,
  input  logic       W_valid_i,
  input  logic       L_valid_i,
  input  logic       N_port_enable,
  input  logic       S_port_enable,
  input  logic       E_port_enable,
  input  logic       W_port_enable,
  input  logic       L_port_enable,
  input  logic       N_credit_ret,
  input  logic       S_credit_ret,
  input  logic       E_credit_ret,
  input  logic       W_credit_ret,
  input  logic       L_credit_ret,
  output logic [4:0] N_turn,
  output logic [4:0] S_turn,
  output logic [4:0] E_turn,
  output logic [4:0] W_turn,
  output logic [4:0] L_turn,
  output logic       N_port_full,
  output logic       S_port_full,
  output logic       E_port_full,
  output logic       W_port_full,
  output logic       L_port_full,
  output logic [4:0] credit_err
);

  // Flow control: port_enable means a granted flit moved through the output
  // this cycle (one credit consumed); credit_ret means downstream freed one
  // slot. Both are single-cycle pulses; turn and port_full are registered so
  // route logic can sample them in the same cycle it raises port_enable.

  logic [7:0] data_in [NUM_PORTS];
  logic       valid_in[NUM_PORTS];
  logic       enable  [NUM_PORTS];
  logic       ret     [NUM_PORTS];
  logic [4:0] req     [NUM_PORTS];
  logic [4:0] turn    [NUM_PORTS];
  logic       full    [NUM_PORTS];

  assign data_in[0] = N_data_i;
  assign data_in[1] = S_data_i;
  assign data_in[2] = E_data_i;
  assign data_in[3] = W_data_i;
  assign data_in[4] = L_data_i;

  assign valid_in[0] = N_valid_i;
  assign valid_in[1] = S_valid_i;
  assign valid_in[2] = E_valid_i;
  assign valid_in[3] = W_valid_i;
  assign valid_in[4] = L_valid_i;

  assign enable[0] = N_port_enable;
  assign enable[1] = S_port_enable;
  assign enable[2] = E_port_enable;
  assign enable[3] = W_port_enable;
  assign enable[4] = L_port_enable;

  assign ret[0] = N_credit_ret;
  assign ret[1] = S_credit_ret;
  assign ret[2] = E_credit_ret;
  assign ret[3] = W_credit_ret;
  assign ret[4] = L_credit_ret;

  // req[o] is indexed by input in turn order (N at bit 4).
  always_comb begin
    port_e dest;
    for (int o = 0; o < 5; o++) req[o] = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      dest = route_xy(data_in[i], 4'(XCOORD), 4'(YCOORD));
      if (valid_in[i]) req[dest][port_bit(3'(i))] = 1'b1;
    end
  end

  for (genvar o = 0; o < 5; o++) begin : g_out
    noc_out_arbiter #(
      .BUF_DEPTH (BUF_DEPTH)
    ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (req[o]),
      .port_enable (enable[o]),
      .credit_ret  (ret[o]),
      .turn        (turn[o]),
      .port_full   (full[o]),
      .credit_err  (credit_err[4-o])
    );
  end

  assign N_turn = turn[0];
  assign S_turn = turn[1];
  assign E_turn = turn[2];
  assign W_turn = turn[3];
  assign L_turn = turn[4];

  assign N_port_full = full[0];
  assign S_port_full = full[1];
  assign E_port_full = full[2];
  assign W_port_full = full[3];
  assign L_port_full = full[4];

endmodule

// File: tb/tb_noc_turn_scheduler.sv
// Directed and randomized checks of noc_turn_scheduler against a port-index
// level reference model.
module tb_noc_turn_scheduler;

  localparam int XC = 1;
  localparam int YC = 1;
  localparam int BD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i [5];
  logic       valid_i[5];
  logic       en_i   [5];
  logic       ret_i  [5];
  logic [4:0] turn_o [5];
  logic       full_o [5];
  logic [4:0] credit_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: holder as port index 0..4 (N,S,E,W,L), plain int credits.
  int m_hold[5];
  int m_cred[5];
  bit m_err [5];

  always #5 clk = ~clk;

  noc_turn_scheduler #(.XCOORD(XC), .YCOORD(YC), .BUF_DEPTH(BD)) dut (
    .clk(clk), .rst(rst),
    .N_data_i(data_i[0]), .S_data_i(data_i[1]), .E_data_i(data_i[2]),
    .W_data_i(data_i[3]), .L_data_i(data_i[4]),
    .N_valid_i(valid_i[0]), .S_valid_i(valid_i[1]), .E_valid_i(valid_i[2]),
    .W_valid_i(valid_i[3]), .L_valid_i(valid_i[4]),
    .N_port_enable(en_i[0]), .S_port_enable(en_i[1]), .E_port_enable(en_i[2]),
    .W_port_enable(en_i[3]), .L_port_enable(en_i[4]),
    .N_credit_ret(ret_i[0]), .S_credit_ret(ret_i[1]), .E_credit_ret(ret_i[2]),
    .W_credit_ret(ret_i[3]), .L_credit_ret(ret_i[4]),
    .N_turn(turn_o[0]), .S_turn(turn_o[1]), .E_turn(turn_o[2]),
    .W_turn(turn_o[3]), .L_turn(turn_o[4]),
    .N_port_full(full_o[0]), .S_port_full(full_o[1]), .E_port_full(full_o[2]),
    .W_port_full(full_o[3]), .L_port_full(full_o[4]),
    .credit_err(credit_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dest_port(input logic [7:0] d);
    int x = int'(d[7:4]);
    int y = int'(d[3:0]);
    if (y > YC) return 1;
    if (y < YC) return 0;
    if (x > XC) return 2;
    if (x < XC) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    for (int o = 0; o < 5; o++) begin
      m_hold[o] = 0;
      m_cred[o] = BD;
      m_err[o]  = 1'b0;
    end
  endtask

  task automatic model_step();
    bit wants[5][5];
    for (int o = 0; o < 5; o++)
      for (int i = 0; i < 5; i++) wants[o][i] = 1'b0;
    for (int i = 0; i < 5; i++)
      if (valid_i[i]) wants[dest_port(data_i[i])][i] = 1'b1;
    for (int o = 0; o < 5; o++) begin
      if (en_i[o] || !wants[o][m_hold[o]]) begin
        int found = -1;
        for (int k = 1; k < 5; k++) begin
          int j = (m_hold[o] + k) % 5;
          if (found < 0 && wants[o][j]) found = j;
        end
        if (found >= 0) m_hold[o] = found;
      end
      if (en_i[o] && !ret_i[o]) begin
        if (m_cred[o] == 0) m_err[o] = 1'b1;
        else m_cred[o]--;
      end else if (ret_i[o] && !en_i[o]) begin
        if (m_cred[o] == BD) m_err[o] = 1'b1;
        else m_cred[o]++;
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic [4:0] exp_err;
    for (int o = 0; o < 5; o++) begin
      check($sformatf("%s_turn%0d", tag, o), 32'(turn_o[o]), 32'(5'b10000 >> m_hold[o]));
      check($sformatf("%s_full%0d", tag, o), 32'(full_o[o]), 32'(m_cred[o] == 0));
      exp_err[4-o] = m_err[o];
    end
    check($sformatf("%s_err", tag), 32'(credit_err), 32'(exp_err));
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 5; i++) begin
      data_i[i] = 8'h00; valid_i[i] = 1'b0; en_i[i] = 1'b0; ret_i[i] = 1'b0;
    end
  endtask

  // Inputs are already set; model advances, then DUT is sampled 1 after the edge.
  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int o = 0; o < 5; o++) begin
      check($sformatf("%s_rturn%0d", tag, o), 32'(turn_o[o]), 32'h10);
      check($sformatf("%s_rfull%0d", tag, o), 32'(full_o[o]), 32'h0);
    end
    check($sformatf("%s_rerr", tag), 32'(credit_err), 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    check_model(tag);
  endtask

  initial begin
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_model("reset");

    // Round robin on L among N, W, L
    valid_i[0] = 1'b1; data_i[0] = 8'h11;
    valid_i[3] = 1'b1; data_i[3] = 8'h11;
    valid_i[4] = 1'b1; data_i[4] = 8'h11;
    en_i[4] = 1'b1;
    cycle("rr1"); check("rr_seq1", 32'(turn_o[4]), 32'h02);
    cycle("rr2"); check("rr_seq2", 32'(turn_o[4]), 32'h01);
    cycle("rr3"); check("rr_seq3", 32'(turn_o[4]), 32'h10);

    // Idle holder N skipped on E
    clear_inputs();
    valid_i[1] = 1'b1; data_i[1] = 8'h21;
    cycle("skip"); check("skip_e_turn", 32'(turn_o[2]), 32'h08);

    // Credit exhaustion on S
    clear_inputs();
    en_i[1] = 1'b1;
    for (int k = 0; k < 4; k++) cycle("sx");
    check("s_full_set", 32'(full_o[1]), 32'h1);
    clear_inputs();
    ret_i[1] = 1'b1;
    cycle("sret"); check("s_full_clr", 32'(full_o[1]), 32'h0);

    // Simultaneous enable and return on E at 2 credits
    clear_inputs();
    en_i[2] = 1'b1;
    cycle("e1"); cycle("e2");
    ret_i[2] = 1'b1;
    cycle("esim"); check("e_sim_full", 32'(full_o[2]), 32'h0);
    ret_i[2] = 1'b0;
    cycle("e3"); check("e_one_left", 32'(full_o[2]), 32'h0);
    cycle("e4"); check("e_empty", 32'(full_o[2]), 32'h1);

    // Return at full credits on W
    clear_inputs();
    ret_i[3] = 1'b1;
    cycle("werr"); check("w_err_set", 32'(credit_err), 32'h02);
    clear_inputs();
    cycle("whold"); check("w_err_hold", 32'(credit_err), 32'h02);
    en_i[3] = 1'b1;
    for (int k = 0; k < 3; k++) cycle("wdec");
    check("w_not_full", 32'(full_o[3]), 32'h0);
    cycle("wdec4"); check("w_full", 32'(full_o[3]), 32'h1);
    check("w_err_still", 32'(credit_err), 32'h02);

    // Mid-cycle asynchronous reset with an enable in flight
    en_i[0] = 1'b1; ret_i[2] = 1'b1;
    async_reset("ar");
    clear_inputs();

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 5; i++) begin
        valid_i[i] = ($urandom_range(0, 3) != 0);
        data_i[i]  = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2))};
        en_i[i]    = ($urandom_range(0, 2) == 0);
        ret_i[i]   = ($urandom_range(0, 2) == 0);
      end
      if (n % 97 == 96) async_reset("rnd");
      else cycle("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
